// File: rtl/alu_seq.sv
// alu_seq: sequential WIDTH-bit ALU with valid/ready handshakes on both sides.
//
// Opcode {m,s1,s0}:
//   000 AND, 001 OR, 010 XOR, 011 NOT A,
//   100 ADD, 101 SUB, 110 MUL (unsigned, multi-cycle), 111 unsigned A<B.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   m, s1, s0         opcode
//   A, B              operands; for MUL, A is the multiplicand and B the multiplier
//   in_valid/in_ready input handshake; in_ready is high only in IDLE
//   out, out_hi       result; {out_hi, out} is the full product for MUL, out_hi=0 otherwise
//   carry, zero, ovf  status flags for the registered result
//   out_valid/out_ready output handshake; the result is held until it is taken
//
// Non-multiply ops register their result at the accept edge. MUL runs one
// shift-add iteration per cycle for WIDTH cycles, then registers the product.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m,
  input  logic             s1,
  input  logic             s0,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int                CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;
  op_e    op;
  logic   accept;

  assign op        = op_e'({m, s1, s0});
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath for every op except MUL
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             res_carry;
  logic             res_ovf;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    sum       = {1'b0, A} + {1'b0, B};
    diff      = {1'b0, A} - {1'b0, B};
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    case (op)
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_NOT: res = ~A;
      OP_ADD: begin
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        // Operands of equal sign producing a result of the other sign.
        res_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res       = diff[WIDTH-1:0];
        // The extra bit of the widened difference is the borrow (A < B).
        res_carry = diff[WIDTH];
        res_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_CMP: res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      default: ;  // OP_MUL is handled by the iterative datapath
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift-add multiplier: the multiplicand shifts left and the multiplier
  // shifts right each cycle, so bit 0 of mplier is always the current bit.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;

  assign acc_next  = acc + (mplier[0] ? mcand : '0);
  assign last_iter = (cnt == LAST_ITER);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (op == OP_MUL) ? MUL : DONE;
      MUL:  if (last_iter) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out    <= '0;
      out_hi <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
              cnt    <= '0;
            end else begin
              out    <= res;
              out_hi <= '0;
              carry  <= res_carry;
              zero   <= (res == '0);
              ovf    <= res_ovf;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            out    <= acc_next[WIDTH-1:0];
            out_hi <= acc_next[2*WIDTH-1:WIDTH];
            carry  <= |acc_next[2*WIDTH-1:WIDTH];
            zero   <= (acc_next == '0);
            ovf    <= 1'b0;
          end
        end
        default: ;  // DONE: hold the result until it is taken
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=4). Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_alu_seq;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             m = 1'b0, s1 = 1'b0, s0 = 1'b0;
  logic [WIDTH-1:0] A = '0, B = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out, out_hi;
  logic             carry, zero, ovf;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m        (m),
    .s1       (s1),
    .s0       (s0),
    .A        (A),
    .B        (B),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_hi   (out_hi),
    .carry    (carry),
    .zero     (zero),
    .ovf      (ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Present one operation for a single edge; returns 1 unit after that edge.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    {m, s1, s0} = op;
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Take the pending result with a one-cycle out_ready pulse.
  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if ({out, out_hi, carry, zero, ovf} !== '0)
      begin errors++; $display("FAIL reset_outputs: out=%b out_hi=%b c=%b z=%b o=%b want all 0", out, out_hi, carry, zero, ovf); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_logic();
    logic [WIDTH-1:0] exp_out [4];
    exp_out[0] = 4'b0010;
    exp_out[1] = 4'b1111;
    exp_out[2] = 4'b1101;
    exp_out[3] = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL logic%0d_in_ready: got %b want 1", i, in_ready); end
      issue({1'b0, 2'(i)}, 4'b1010, 4'b0111);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL logic%0d_out_valid: got %b want 1", i, out_valid); end
      checks++; if (out !== exp_out[i]) begin errors++; $display("FAIL logic%0d_out: got %b want %b", i, out, exp_out[i]); end
      checks++; if ({out_hi, carry, ovf, zero} !== 7'b0) begin errors++; $display("FAIL logic%0d_flags: out_hi=%b c=%b o=%b z=%b want 0", i, out_hi, carry, ovf, zero); end
      handshake();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL logic%0d_handshake: out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_arith();
    // {op, A, B, out, carry, ovf, zero}
    logic [2:0]       v_op  [6];
    logic [WIDTH-1:0] v_a   [6];
    logic [WIDTH-1:0] v_b   [6];
    logic [WIDTH-1:0] v_out [6];
    logic [2:0]       v_cov [6];
    v_op[0] = 3'b100; v_a[0] = 4'b1010; v_b[0] = 4'b0111; v_out[0] = 4'b0001; v_cov[0] = 3'b100;
    v_op[1] = 3'b101; v_a[1] = 4'b1010; v_b[1] = 4'b0111; v_out[1] = 4'b0011; v_cov[1] = 3'b010;
    v_op[2] = 3'b101; v_a[2] = 4'b0011; v_b[2] = 4'b0011; v_out[2] = 4'b0000; v_cov[2] = 3'b001;
    v_op[3] = 3'b101; v_a[3] = 4'b0111; v_b[3] = 4'b1010; v_out[3] = 4'b1101; v_cov[3] = 3'b110;
    v_op[4] = 3'b111; v_a[4] = 4'b1010; v_b[4] = 4'b0111; v_out[4] = 4'b0000; v_cov[4] = 3'b001;
    v_op[5] = 3'b111; v_a[5] = 4'b0111; v_b[5] = 4'b1010; v_out[5] = 4'b0001; v_cov[5] = 3'b000;
    for (int i = 0; i < 6; i++) begin
      issue(v_op[i], v_a[i], v_b[i]);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arith%0d_out_valid: got %b want 1", i, out_valid); end
      checks++; if (out !== v_out[i] || out_hi !== 4'b0) begin errors++; $display("FAIL arith%0d_out: got %b/%b want 0000/%b", i, out_hi, out, v_out[i]); end
      checks++; if ({carry, ovf, zero} !== v_cov[i]) begin errors++; $display("FAIL arith%0d_flags: c,o,z got %b want %b", i, {carry, ovf, zero}, v_cov[i]); end
      handshake();
    end
  endtask

  task automatic test_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] e_hi, input logic [WIDTH-1:0] e_lo,
                          input logic e_c, input logic e_z);
    issue(3'b110, a, b);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mul_accept: out_valid=%b in_ready=%b want 0/0", out_valid, in_ready); end
    for (int i = 1; i < WIDTH; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy%0d: out_valid=%b in_ready=%b want 0/0", i, out_valid, in_ready); end
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_latency: out_valid=%b want 1 at accept+%0d", out_valid, WIDTH); end
    checks++; if (out_hi !== e_hi || out !== e_lo) begin errors++; $display("FAIL mul_product %b*%b: got %b_%b want %b_%b", a, b, out_hi, out, e_hi, e_lo); end
    checks++; if ({carry, zero, ovf} !== {e_c, e_z, 1'b0}) begin errors++; $display("FAIL mul_flags: c,z,o got %b want %b", {carry, zero, ovf}, {e_c, e_z, 1'b0}); end
    handshake();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mul_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    issue(3'b010, 4'b1100, 4'b0110);  // XOR -> 1010
    checks++; if (out_valid !== 1'b1 || out !== 4'b1010) begin errors++; $display("FAIL b2b_first: out_valid=%b out=%b want 1/1010", out_valid, out); end
    @(posedge clk); #1;               // handshake edge
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    issue(3'b100, 4'b0101, 4'b0011);  // ADD -> 1000, signed overflow
    checks++; if (out_valid !== 1'b1 || out !== 4'b1000 || {carry, ovf, zero} !== 3'b010)
      begin errors++; $display("FAIL b2b_second: out_valid=%b out=%b c,o,z=%b want 1/1000/010", out_valid, out, {carry, ovf, zero}); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    issue(3'b100, 4'b1010, 4'b0111);  // ADD -> 0001, carry
    in_valid = 1'b1;                  // must be ignored outside IDLE
    {m, s1, s0} = 3'b000;
    A = 4'b0000;
    B = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 4'b0001 || out_hi !== 4'b0 || {carry, ovf, zero} !== 3'b100) begin
        errors++;
        $display("FAIL backpressure_hold%0d: out_valid=%b in_ready=%b out=%b c,o,z=%b want 1/0/0001/100", i, out_valid, in_ready, out, {carry, ovf, zero});
      end
    end
    in_valid = 1'b0;
    handshake();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (out !== 4'b0001 || carry !== 1'b1) begin errors++; $display("FAIL backpressure_retain: out=%b carry=%b want 0001/1", out, carry); end
  endtask

  task automatic test_reset_mid_mul();
    logic spurious;
    issue(3'b110, 4'b1010, 4'b0111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({out, out_hi, carry, zero, ovf, out_valid} !== '0)
      begin errors++; $display("FAIL midreset_outputs: out=%b out_hi=%b c=%b z=%b o=%b v=%b want all 0", out, out_hi, carry, zero, ovf, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious = 1'b1;
    end
    out_ready = 1'b0;
    checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL midreset_spurious: out_valid/in_ready deviated from 0/1 after release"); end
    issue(3'b100, 4'b0011, 4'b0100);  // ADD -> 0111
    checks++; if (out_valid !== 1'b1 || out !== 4'b0111 || {carry, ovf, zero} !== 3'b000)
      begin errors++; $display("FAIL midreset_add: out_valid=%b out=%b c,o,z=%b want 1/0111/000", out_valid, out, {carry, ovf, zero}); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_logic();
    test_arith();
    test_mul(4'b1010, 4'b0111, 4'b0100, 4'b0110, 1'b1, 1'b0);
    test_mul(4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    test_mul(4'b1111, 4'b1111, 4'b1110, 4'b0001, 1'b1, 1'b0);
    test_mul(4'b0011, 4'b0010, 4'b0000, 4'b0110, 1'b0, 1'b0);
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
